// File: rtl/hssl_link_controller_if.sv
// Control/status bundle between the HSSL link controller and the
// transceiver wrapper / top-level status logic.
interface hssl_link_controller_if;
    logic       enable_in;
    logic       tx_usrclk_active_in;
    logic       tx_reset_done_in;
    logic       rx_reset_done_in;
    logic       rx_commadet_in;
    logic       rx_err_in;
    logic       handshake_complete_in;
    logic       tx_reset_datapath_out;
    logic       rx_reset_datapath_out;
    logic       tx_elec_idle_out;
    logic       handshake_start_out;
    logic       link_up_out;
    logic [2:0] state_out;
    logic [7:0] retry_cnt_out;

    // master: the link controller; slave: the transceiver-side logic
    modport master (
        input  enable_in, tx_usrclk_active_in, tx_reset_done_in, rx_reset_done_in,
               rx_commadet_in, rx_err_in, handshake_complete_in,
        output tx_reset_datapath_out, rx_reset_datapath_out, tx_elec_idle_out,
               handshake_start_out, link_up_out, state_out, retry_cnt_out
    );

    modport slave (
        output enable_in, tx_usrclk_active_in, tx_reset_done_in, rx_reset_done_in,
               rx_commadet_in, rx_err_in, handshake_complete_in,
        input  tx_reset_datapath_out, rx_reset_datapath_out, tx_elec_idle_out,
               handshake_start_out, link_up_out, state_out, retry_cnt_out
    );
endinterface

// File: rtl/hssl_link_controller.sv
// Bring-up and recovery sequencer for one HSSL lane: TX/RX datapath resets,
// comma alignment, handshake, error-rate monitoring and timed back-off.
module hssl_link_controller #(
    parameter int RST_PULSE_LEN = 128,
    parameter int DONE_TIMEOUT  = 1000000,
    parameter int ALIGN_TIMEOUT = 1000000,
    parameter int HS_TIMEOUT    = 75000000,
    parameter int ERR_WINDOW    = 65536,
    parameter int ERR_THRESH    = 16,
    parameter int BACKOFF_LEN   = 1000000
) (
    input  logic clk_in,
    input  logic reset_n_in,
    hssl_link_controller_if.master link
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The reset states share the timer across pulse and done-wait, so the
    // timer must reach pulse + wait.
    localparam int RST_WAIT_LEN = RST_PULSE_LEN + DONE_TIMEOUT;
    localparam int MAX_LIMIT    = max2(max2(RST_WAIT_LEN, ALIGN_TIMEOUT),
                                       max2(HS_TIMEOUT, BACKOFF_LEN));
    localparam int TMR_W = $clog2(MAX_LIMIT + 1);
    localparam int ERR_W = $clog2(ERR_THRESH + 1);
    localparam int WIN_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;

    localparam logic [TMR_W-1:0] PULSE_T      = TMR_W'(RST_PULSE_LEN);
    localparam logic [TMR_W-1:0] RST_WAIT_END = TMR_W'(RST_WAIT_LEN - 1);
    localparam logic [TMR_W-1:0] ALIGN_END    = TMR_W'(ALIGN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HS_END       = TMR_W'(HS_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] BACKOFF_END  = TMR_W'(BACKOFF_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_END      = WIN_W'(ERR_WINDOW - 1);
    localparam logic [ERR_W:0]   ERR_TRIP     = (ERR_W + 1)'(ERR_THRESH);
    localparam logic [ERR_W-1:0] ERR_CAP      = ERR_W'(ERR_THRESH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_RST  = 3'd1,
        ST_RX_RST  = 3'd2,
        ST_ALIGN   = 3'd3,
        ST_HSHAKE  = 3'd4,
        ST_UP      = 3'd5,
        ST_BACKOFF = 3'd6
    } state_t;

    function automatic logic [7:0] retry_sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    function automatic logic [ERR_W-1:0] err_sat_add(input logic [ERR_W-1:0] cnt,
                                                     input logic            hit);
        logic [ERR_W:0] sum;
        sum = {1'b0, cnt} + {{ERR_W{1'b0}}, hit};
        return (sum >= ERR_TRIP) ? ERR_CAP : sum[ERR_W-1:0];
    endfunction

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [ERR_W-1:0] err_cnt, err_nxt;
    logic [WIN_W-1:0] win_cnt, win_nxt;
    logic [7:0]       retry_cnt;
    logic             tx_rst_q, rx_rst_q, elec_idle_q, hs_start_q, link_up_q;
    logic             pulse_done, err_trip, health_ok;

    always_comb begin
        state_nxt  = state;
        pulse_done = (timer >= PULSE_T);
        err_trip   = (({1'b0, err_cnt} + {{ERR_W{1'b0}}, link.rx_err_in}) >= ERR_TRIP);
        health_ok  = link.handshake_complete_in & link.rx_reset_done_in & link.tx_reset_done_in;

        // Exit conditions are tested before timeouts so they win a tie.
        case (state)
            ST_IDLE:
                if (link.tx_usrclk_active_in) state_nxt = ST_TX_RST;
            ST_TX_RST:
                if (pulse_done && link.tx_reset_done_in) state_nxt = ST_RX_RST;
                else if (timer == RST_WAIT_END)          state_nxt = ST_BACKOFF;
            ST_RX_RST:
                if (pulse_done && link.rx_reset_done_in) state_nxt = ST_ALIGN;
                else if (timer == RST_WAIT_END)          state_nxt = ST_BACKOFF;
            ST_ALIGN:
                if (link.rx_commadet_in)   state_nxt = ST_HSHAKE;
                else if (timer == ALIGN_END) state_nxt = ST_BACKOFF;
            ST_HSHAKE:
                if (link.handshake_complete_in) state_nxt = ST_UP;
                else if (timer == HS_END)       state_nxt = ST_BACKOFF;
            ST_UP:
                if (err_trip || !health_ok) state_nxt = ST_BACKOFF;
            ST_BACKOFF:
                if (timer == BACKOFF_END) state_nxt = ST_TX_RST;
            default:
                state_nxt = ST_IDLE;
        endcase

        if (!link.enable_in) state_nxt = ST_IDLE;

        timer_nxt = (state_nxt != state) ? '0 : timer + TMR_W'(1);

        // Error window only runs while staying in UP; any entry or exit clears it.
        err_nxt = '0;
        win_nxt = '0;
        if (state == ST_UP && state_nxt == ST_UP) begin
            win_nxt = (win_cnt == WIN_END) ? '0 : win_cnt + WIN_W'(1);
            err_nxt = (win_cnt == WIN_END) ? '0 : err_sat_add(err_cnt, link.rx_err_in);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state       <= ST_IDLE;
            timer       <= '0;
            err_cnt     <= '0;
            win_cnt     <= '0;
            retry_cnt   <= '0;
            tx_rst_q    <= 1'b0;
            rx_rst_q    <= 1'b0;
            elec_idle_q <= 1'b0;
            hs_start_q  <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            err_cnt <= err_nxt;
            win_cnt <= win_nxt;
            if (state_nxt == ST_BACKOFF && state != ST_BACKOFF)
                retry_cnt <= retry_sat_inc(retry_cnt);
            // Decoded from next state/timer so outputs track the state register.
            tx_rst_q    <= (state_nxt == ST_TX_RST) && (timer_nxt < PULSE_T);
            rx_rst_q    <= (state_nxt == ST_RX_RST) && (timer_nxt < PULSE_T);
            elec_idle_q <= (state_nxt == ST_BACKOFF);
            hs_start_q  <= (state_nxt == ST_HSHAKE) || (state_nxt == ST_UP);
            link_up_q   <= (state_nxt == ST_UP);
        end
    end

    assign link.tx_reset_datapath_out = tx_rst_q;
    assign link.rx_reset_datapath_out = rx_rst_q;
    assign link.tx_elec_idle_out      = elec_idle_q;
    assign link.handshake_start_out   = hs_start_q;
    assign link.link_up_out           = link_up_q;
    assign link.state_out             = state;
    assign link.retry_cnt_out         = retry_cnt;

endmodule

// File: tb/tb_hssl_link_controller.sv
// Self-checking bench for hssl_link_controller: each attempt's state trace is
// predicted from its planned input timing and compared cycle by cycle.
module tb_hssl_link_controller;
    localparam int P_PULSE = 4;
    localparam int P_DONE  = 20;
    localparam int P_ALIGN = 20;
    localparam int P_HS    = 50;
    localparam int P_WIN   = 32;
    localparam int P_THR   = 3;
    localparam int P_BO    = 10;
    localparam int NEVER   = 1 << 30;

    localparam int S_IDLE = 0, S_TX = 1, S_RX = 2, S_AL = 3, S_HS = 4, S_UP = 5, S_BO = 6;

    logic clk_in;
    logic reset_n_in;
    hssl_link_controller_if lnk ();

    hssl_link_controller #(
        .RST_PULSE_LEN(P_PULSE), .DONE_TIMEOUT(P_DONE), .ALIGN_TIMEOUT(P_ALIGN),
        .HS_TIMEOUT(P_HS), .ERR_WINDOW(P_WIN), .ERR_THRESH(P_THR), .BACKOFF_LEN(P_BO)
    ) dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .link(lnk)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks  = 0;
    int n_errs    = 0;
    int exp_retry = 0;
    bit err_at [int];
    int drop_kind = 0;   // 0 none, 1 enable drop, 2 health drop
    int drop_at   = NEVER;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic noise_err();
        lnk.rx_err_in = 1'($urandom_range(0, 1));
    endtask

    task automatic noise_comma();
        lnk.rx_commadet_in = 1'($urandom_range(0, 1));
    endtask

    // Expected outputs follow directly from the state and cycle index in it.
    task automatic expect_cyc(input int st, input int idx);
        logic [4:0] exp_o, obs_o;
        exp_o = {(st == S_TX) && (idx < P_PULSE), (st == S_RX) && (idx < P_PULSE),
                 (st == S_BO), (st == S_HS) || (st == S_UP), (st == S_UP)};
        obs_o = {lnk.tx_reset_datapath_out, lnk.rx_reset_datapath_out, lnk.tx_elec_idle_out,
                 lnk.handshake_start_out, lnk.link_up_out};
        chk($sformatf("state s%0d i%0d", st, idx), 32'(lnk.state_out), 32'(st));
        chk($sformatf("outputs s%0d i%0d", st, idx), 32'(obs_o), 32'(exp_o));
        chk($sformatf("retry s%0d i%0d", st, idx), 32'(lnk.retry_cnt_out), 32'(exp_retry));
    endtask

    task automatic do_idle(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            expect_cyc(S_IDLE, i);
            r = int'($urandom_range(0, 2));
            lnk.enable_in           = (i == n - 1) || (r == 1);
            lnk.tx_usrclk_active_in = (i == n - 1) || (r == 2);
            noise_err();
            noise_comma();
            tick();
        end
    endtask

    // d: cycles after the pulse before done rises (>= P_DONE means too late)
    task automatic do_rst(input bit is_tx, input int d, output bit passed);
        int   len;
        logic v;
        len    = (d < P_DONE) ? P_PULSE + d + 1 : P_PULSE + P_DONE;
        passed = (d < P_DONE);
        for (int i = 0; i < len; i++) begin
            expect_cyc(is_tx ? S_TX : S_RX, i);
            v = (i < P_PULSE) ? 1'($urandom_range(0, 1)) : 1'(i >= P_PULSE + d);
            if (is_tx) lnk.tx_reset_done_in = v;
            else       lnk.rx_reset_done_in = v;
            noise_err();
            noise_comma();
            tick();
        end
    endtask

    task automatic do_align(input int c, output bit passed);
        int len;
        len    = (c < P_ALIGN) ? c + 1 : P_ALIGN;
        passed = (c < P_ALIGN);
        for (int i = 0; i < len; i++) begin
            expect_cyc(S_AL, i);
            lnk.rx_commadet_in = (i == c);
            noise_err();
            tick();
        end
        lnk.rx_commadet_in = 1'b0;
    endtask

    task automatic do_hs(input int h, output bit passed);
        int len;
        len    = (h < P_HS) ? h + 1 : P_HS;
        passed = (h < P_HS);
        for (int i = 0; i < len; i++) begin
            expect_cyc(S_HS, i);
            lnk.handshake_complete_in = (i >= h);
            noise_err();
            noise_comma();
            tick();
        end
    endtask

    // UP length: first cycle where one fixed 32-cycle window holds 3 errors,
    // or the planned drop, whichever comes first.
    task automatic do_up(output int nxt);
        int err_end, drop_end, len, cnt;
        err_end = NEVER;
        cnt     = 0;
        for (int i = 0; i < 5000 && err_end == NEVER; i++) begin
            if (i % P_WIN == 0) cnt = 0;
            if (err_at.exists(i)) cnt++;
            if (cnt >= P_THR) err_end = i + 1;
        end
        drop_end = (drop_kind != 0) ? drop_at + 1 : NEVER;
        len      = (err_end < drop_end) ? err_end : drop_end;
        if (len > 5000) len = 5000;
        nxt = (drop_kind == 1 && drop_end <= err_end) ? S_IDLE : S_BO;
        for (int i = 0; i < len; i++) begin
            expect_cyc(S_UP, i);
            lnk.rx_err_in = 1'(err_at.exists(i));
            noise_comma();
            if (i == drop_at && drop_kind == 1) lnk.enable_in = 1'b0;
            if (i == drop_at && drop_kind == 2) begin
                case ($urandom_range(0, 2))
                    0:       lnk.handshake_complete_in = 1'b0;
                    1:       lnk.rx_reset_done_in      = 1'b0;
                    default: lnk.tx_reset_done_in      = 1'b0;
                endcase
            end
            tick();
        end
        lnk.rx_err_in = 1'b0;
    endtask

    task automatic do_backoff();
        exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
        for (int i = 0; i < P_BO; i++) begin
            expect_cyc(S_BO, i);
            lnk.tx_reset_done_in      = 1'b0;
            lnk.rx_reset_done_in      = 1'b0;
            lnk.handshake_complete_in = 1'b0;
            noise_err();
            noise_comma();
            tick();
        end
    endtask

    task automatic attempt(input int dtx, input int drx, input int c, input int h, output int nxt);
        bit ok;
        nxt = S_BO;
        do_rst(1'b1, dtx, ok);
        if (!ok) return;
        do_rst(1'b0, drx, ok);
        if (!ok) return;
        do_align(c, ok);
        if (!ok) return;
        do_hs(h, ok);
        if (!ok) return;
        do_up(nxt);
    endtask

    task automatic finish_attempt(input int nxt);
        err_at.delete();
        drop_kind = 0;
        drop_at   = NEVER;
        if (nxt == S_BO) do_backoff();
        else             do_idle(int'($urandom_range(1, 5)));
    endtask

    initial begin
        int nxt;
        int p1, p2, p3;
        lnk.enable_in             = 1'b0;
        lnk.tx_usrclk_active_in   = 1'b0;
        lnk.tx_reset_done_in      = 1'b0;
        lnk.rx_reset_done_in      = 1'b0;
        lnk.rx_commadet_in        = 1'b0;
        lnk.rx_err_in             = 1'b0;
        lnk.handshake_complete_in = 1'b0;
        reset_n_in = 1'b1;
        #1 reset_n_in = 1'b0;
        #1 expect_cyc(S_IDLE, 0);
        tick();
        tick();
        reset_n_in = 1'b1;
        do_idle(3);

        // Nominal bring-up, then 2 errors per window for 10 windows, a window-edge
        // error followed by 2 more, and finally a 3-error burst.
        for (int w = 0; w < 10; w++) begin
            p1 = int'($urandom_range(0, P_WIN - 1));
            p2 = (p1 + int'($urandom_range(1, P_WIN - 1))) % P_WIN;
            err_at[w * P_WIN + p1] = 1'b1;
            err_at[w * P_WIN + p2] = 1'b1;
        end
        err_at[11 * P_WIN - 1] = 1'b1;
        err_at[11 * P_WIN]     = 1'b1;
        err_at[11 * P_WIN + 1] = 1'b1;
        p1 = int'($urandom_range(0, P_WIN - 3));
        p2 = int'($urandom_range(p1 + 1, P_WIN - 2));
        p3 = int'($urandom_range(p2 + 1, P_WIN - 1));
        err_at[12 * P_WIN + p1] = 1'b1;
        err_at[12 * P_WIN + p2] = 1'b1;
        err_at[12 * P_WIN + p3] = 1'b1;
        attempt(2, 2, 3, 5, nxt);
        finish_attempt(nxt);

        // Handshake timeout.
        attempt(0, 1, 0, NEVER, nxt);
        finish_attempt(nxt);

        // Exit on the final allowed cycle of every wait, then a health drop in UP.
        drop_kind = 2;
        drop_at   = int'($urandom_range(0, 40));
        attempt(P_DONE - 1, P_DONE - 1, P_ALIGN - 1, P_HS - 1, nxt);
        finish_attempt(nxt);

        // Done and align timeouts.
        attempt(P_DONE, 0, 0, 0, nxt);
        finish_attempt(nxt);
        attempt(0, P_DONE + 3, 0, 0, nxt);
        finish_attempt(nxt);
        attempt(0, 0, NEVER, 0, nxt);
        finish_attempt(nxt);

        // Enable dropped in UP: IDLE with outputs cleared and retry count held.
        err_at[3] = 1'b1;
        drop_kind = 1;
        drop_at   = 10;
        attempt(1, 1, 1, 1, nxt);
        finish_attempt(nxt);

        // Randomised attempts.
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 150; i++)
                if ($urandom_range(0, 9) == 0) err_at[i] = 1'b1;
            drop_kind = int'($urandom_range(1, 2));
            drop_at   = int'($urandom_range(0, 149));
            attempt(int'($urandom_range(0, P_DONE + 2)), int'($urandom_range(0, P_DONE + 2)),
                    int'($urandom_range(0, P_ALIGN + 2)), int'($urandom_range(0, P_HS + 2)), nxt);
            finish_attempt(nxt);
        end

        // Asynchronous reset in the middle of the TX reset pulse.
        for (int i = 0; i < 2; i++) begin
            expect_cyc(S_TX, i);
            lnk.tx_reset_done_in = 1'b0;
            tick();
        end
        chk("tx_rst_before_reset", 32'(lnk.tx_reset_datapath_out), 32'd1);
        #2 reset_n_in = 1'b0;
        #1 exp_retry = 0;
        expect_cyc(S_IDLE, 0);
        tick();
        expect_cyc(S_IDLE, 0);
        tick();
        reset_n_in = 1'b1;
        do_idle(2);

        // Retry counter saturation.
        for (int k = 0; k < 260; k++) begin
            attempt(0, 0, 0, NEVER, nxt);
            finish_attempt(nxt);
        end
        chk("retry_saturated", 32'(lnk.retry_cnt_out), 32'd255);
        expect_cyc(S_TX, 0);
        lnk.enable_in = 1'b0;
        tick();
        expect_cyc(S_IDLE, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
